// File: rtl/cipher_uart_tx_pkg.sv
// Shared definitions for the cipher UART transmitter: port map defaults,
// status byte layout and transmitter FSM encoding.
package cipher_uart_tx_pkg;

    localparam logic [7:0] DEFAULT_DATA_PORT   = 8'h08;
    localparam logic [7:0] DEFAULT_STATUS_PORT = 8'h10;

    localparam int unsigned STAT_OVERFLOW  = 7;
    localparam int unsigned STAT_TX_ACTIVE = 2;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] status_byte(input logic overflow,
                                               input logic tx_active,
                                               input logic full,
                                               input logic empty);
        logic [7:0] s;
        s                 = '0;
        s[STAT_OVERFLOW]  = overflow;
        s[STAT_TX_ACTIVE] = tx_active;
        s[STAT_FULL]      = full;
        s[STAT_EMPTY]     = empty;
        return s;
    endfunction

endpackage

// File: rtl/cipher_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
// DEPTH must be a power of two; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // count reaches DEPTH only when its top bit is set (DEPTH is 2**AW)
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cipher_uart_tx.sv
// Processor-port-mapped UART transmitter (8N1) fed by a byte FIFO, with a
// status port reporting overflow, activity and FIFO flags.
module cipher_uart_tx
    import cipher_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [7:0]  DATA_PORT    = DEFAULT_DATA_PORT,
    parameter logic [7:0]  STATUS_PORT  = DEFAULT_STATUS_PORT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] in_port,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t      state;
    tx_state_t      state_next;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           overflow;
    logic           tx_active;
    logic           pop;
    logic           baud_last;
    logic           bit_last;
    logic           data_wr;
    logic           status_wr;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    assign data_wr   = write_strobe && (port_id == DATA_PORT);
    assign status_wr = write_strobe && (port_id == STATUS_PORT);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_cnt == 3'd7);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .pop   (pop),
        .wdata (out_port),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_START;
            ST_START: if (baud_last) state_next = ST_DATA;
            ST_DATA:  if (baud_last && bit_last) state_next = ST_STOP;
            ST_STOP:  if (baud_last) state_next = fifo_empty ? ST_IDLE : ST_START;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_active = (state != ST_IDLE);
        pop       = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));
    end

    // A pop always starts a new frame, whether from IDLE or back-to-back from STOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (pop) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= fifo_rdata;
            tx       <= 1'b0;
        end else begin
            case (state)
                ST_START, ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (state == ST_DATA && bit_last) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                        end else begin
                            if (state == ST_DATA) begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    tx       <= 1'b1;
                    baud_cnt <= baud_last ? '0 : baud_cnt + 16'd1;
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // A dropped byte outranks a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (data_wr && fifo_full) begin
            overflow <= 1'b1;
        end else if (status_wr) begin
            overflow <= 1'b0;
        end
    end

    assign in_port = status_byte(overflow, tx_active, fifo_full, fifo_empty);
    assign busy    = (fifo_count != '0) || tx_active;

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Scoreboard bench for cipher_uart_tx (4 clocks per bit, 4-deep FIFO): accepted
// bytes are queued as expected frames and a serial monitor decodes tx against them.
module tb_cipher_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] in_port;
    logic       tx;
    logic       busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    logic [7:0]  sb[$];
    int unsigned starts[$];

    cipher_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .DATA_PORT    (8'h08),
        .STATUS_PORT  (8'h10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .in_port      (in_port),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] port, input logic [7:0] data,
                              output int unsigned edge_c);
        port_id      = port;
        out_port     = data;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        edge_c       = cyc;
        write_strobe = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < limit);
        check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Serial monitor: decode one 40-cycle frame per falling start edge
    initial begin : monitor
        logic [39:0] smp;
        logic        aborted;
        logic        fmt_ok;
        logic [7:0]  got;
        int unsigned st;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                st      = cyc;
                smp     = '0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = tx;
                end
                if (!aborted) begin
                    starts.push_back(st);
                    fmt_ok = (smp[3:0] == 4'b0000) && (smp[39:36] == 4'b1111);
                    for (int b = 0; b < 8; b++) begin
                        got[b] = smp[4 + 4*b];
                        for (int j = 1; j < 4; j++) begin
                            if (smp[4 + 4*b + j] !== got[b]) fmt_ok = 1'b0;
                        end
                    end
                    check("frame_format", {31'd0, fmt_ok}, 32'd1);
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got %0h expected no frame", got);
                    end else begin
                        check("frame_byte", {24'd0, got}, {24'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin : stim
        int unsigned n;
        int unsigned n2;
        int unsigned s0;
        logic        low_seen;
        logic [7:0]  dropped;
        logic [7:0]  burst [6];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        port_id      = '0;
        out_port     = '0;
        write_strobe = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_port", {24'd0, in_port}, 32'h01);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // single frame, write accepted on the first edge after reset release
        reset = 1'b0;
        s0 = starts.size();
        sb.push_back(8'hA5);
        write_byte(8'h08, 8'hA5, n);
        wait_cyc(n + 40);
        check("a5_busy_in_stop", {31'd0, busy}, 32'd1);
        wait_cyc(n + 41);
        check("a5_busy_fall", {31'd0, busy}, 32'd0);
        check("a5_start_edge", (starts.size() > s0) ? starts[s0] : 32'd0, n + 1);

        // back-to-back frames with no idle gap
        s0 = starts.size();
        sb.push_back(8'h01);
        sb.push_back(8'h02);
        write_byte(8'h08, 8'h01, n);
        write_byte(8'h08, 8'h02, n2);
        wait_cyc(n + 80);
        check("b2b_busy_in_stop", {31'd0, busy}, 32'd1);
        wait_cyc(n + 81);
        check("b2b_busy_fall", {31'd0, busy}, 32'd0);
        check("b2b_first_start", (starts.size() > s0) ? starts[s0] : 32'd0, n + 1);
        check("b2b_gap", (starts.size() > s0 + 1) ? starts[s0+1] - starts[s0] : 32'd0, 32'd40);
        repeat (4) @(negedge clk);

        // burst of six: one in flight, four buffered, sixth dropped
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(burst[i]);
            write_byte(8'h08, burst[i], n);
        end
        check("burst_status", {24'd0, in_port}, 32'h86);
        write_byte(8'h10, 8'h00, n);
        check("ovf_clear", {24'd0, in_port}, 32'h06);
        dropped = 8'h77;
        write_byte(8'h08, dropped, n);
        check("ovf_set_again", {24'd0, in_port}, 32'h86);
        write_byte(8'h10, 8'h00, n);
        check("ovf_clear_again", {24'd0, in_port}, 32'h06);
        wait_idle(400);
        check("burst_drained", sb.size(), 32'd0);

        // reset during data bit 3 of 8'hFF aborts the frame
        sb.push_back(8'hFF);
        write_byte(8'h08, 8'hFF, n);
        wait_cyc(n + 18);
        check("mid_frame_status", {24'd0, in_port}, 32'h05);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_in_port", {24'd0, in_port}, 32'h01);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        dropped = sb.pop_back();
        s0 = starts.size();
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("post_rst_quiet", {31'd0, low_seen}, 32'd0);
        check("post_rst_no_frame", starts.size(), s0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // transmitter still works after the aborted frame
        sb.push_back(8'h3C);
        write_byte(8'h08, 8'h3C, n);
        wait_idle(100);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
